// File: rtl/instr_mem_loadable.sv
// Runtime-loadable instruction store: sweeps the array to FILL_WORD after reset,
// accepts a program over a valid/ready load port, and serves registered fetches.
module instr_mem_loadable #(
  parameter int                DATA_W    = 10,
  parameter int                ADDR_W    = 10,
  parameter int                DEPTH     = 1024,
  parameter logic [DATA_W-1:0] FILL_WORD = 10'b0010000010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_err,
  output logic              mem_ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_INIT, S_READY, S_LOAD} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_init_ptr;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_ld_count;
  logic                r_ld_done;
  logic [DATA_W-1:0]   r_fetch_data;
  logic                r_fetch_valid;
  logic                r_fetch_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_load_end;
  logic                w_init_end;
  logic                w_fetch;
  logic                w_start;
  logic                w_addr_ok;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;
  logic [DATA_W-1:0]   w_mem_wdata;

  // ld_ready is high exactly in LOAD, so ld_valid alone qualifies a handshake there.
  assign w_accept   = (r_state == S_LOAD) && ld_valid;
  assign w_load_end = w_accept && (ld_last || (r_wr_ptr == LAST_IDX));
  assign w_init_end = (r_state == S_INIT) && (r_init_ptr == LAST_IDX);
  assign w_fetch    = (r_state == S_READY) && fetch_en;
  assign w_start    = (r_state == S_READY) && ld_start;
  assign w_addr_ok  = {1'b0, fetch_addr} < DEPTH_L;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_next_state;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_INIT:  if (w_init_end) w_next_state = S_READY;
      S_READY: if (ld_start)   w_next_state = S_LOAD;
      S_LOAD:  if (w_load_end) w_next_state = S_READY;
      default: w_next_state = S_INIT;
    endcase
  end

  always_comb begin
    ld_ready  = (r_state == S_LOAD);
    mem_ready = (r_state == S_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_ptr <= '0;
      r_wr_ptr   <= '0;
      r_ld_count <= '0;
      r_ld_done  <= 1'b0;
    end else begin
      r_ld_done <= (r_state == S_LOAD) && w_load_end;
      if (r_state == S_INIT) r_init_ptr <= r_init_ptr + 1'b1;
      if (w_start) begin
        r_wr_ptr   <= '0;
        r_ld_count <= '0;
      end else if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_ld_count <= r_ld_count + 1'b1;
      end
    end
  end

  // Single write port shared by the init sweep and the loader; they are state-exclusive.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_wr_ptr;
    w_mem_wdata = ld_data;
    if (r_state == S_INIT) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_init_ptr;
      w_mem_wdata = FILL_WORD;
    end else if (w_accept) begin
      w_mem_we = 1'b1;
    end
  end

  // NOTE: the array has no reset; the INIT sweep provides its known contents.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_data  <= '0;
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch;
      if (w_fetch) begin
        r_fetch_data <= w_addr_ok ? r_mem[fetch_addr] : FILL_WORD;
        r_fetch_err  <= !w_addr_ok;
      end
    end
  end

  assign ld_done     = r_ld_done;
  assign ld_count    = r_ld_count;
  assign fetch_data  = r_fetch_data;
  assign fetch_valid = r_fetch_valid;
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench: a default-size instance plus a DEPTH=8 instance for the overflow case.
module tb_instr_mem_loadable;

  localparam logic [9:0] FILL = 10'b0010000010;

  logic       clk = 1'b0;
  logic       rst_n;
  int         checks = 0;
  int         errors = 0;

  logic       ld_start, ld_valid, ld_ready, ld_last, ld_done;
  logic [9:0] ld_data;
  logic [10:0] ld_count;
  logic       fetch_en, fetch_valid, fetch_err, mem_ready;
  logic [9:0] fetch_addr, fetch_data;

  logic       s_ld_start, s_ld_valid, s_ld_ready, s_ld_last, s_ld_done;
  logic [9:0] s_ld_data;
  logic [10:0] s_ld_count;
  logic       s_fetch_en, s_fetch_valid, s_fetch_err, s_mem_ready;
  logic [9:0] s_fetch_addr, s_fetch_data;

  logic       seen_done;

  always #5 clk = ~clk;

  instr_mem_loadable dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .ld_done(ld_done), .ld_count(ld_count),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .fetch_err(fetch_err), .mem_ready(mem_ready)
  );

  instr_mem_loadable #(.DEPTH(8)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .ld_start(s_ld_start), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready),
    .ld_data(s_ld_data), .ld_last(s_ld_last), .ld_done(s_ld_done), .ld_count(s_ld_count),
    .fetch_en(s_fetch_en), .fetch_addr(s_fetch_addr), .fetch_data(s_fetch_data),
    .fetch_valid(s_fetch_valid), .fetch_err(s_fetch_err), .mem_ready(s_mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_check(input logic [9:0] addr, input logic [9:0] exp, input string tag);
    fetch_en   = 1'b1;
    fetch_addr = addr;
    step();
    check({tag, "_valid"}, fetch_valid, 1);
    check({tag, "_data"}, fetch_data, exp);
    check({tag, "_err"}, fetch_err, 0);
    fetch_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0; fetch_en = 0; fetch_addr = '0;
    s_ld_start = 0; s_ld_valid = 0; s_ld_last = 0; s_ld_data = '0; s_fetch_en = 0; s_fetch_addr = '0;
    seen_done = 1'b0;
    step(); step();
    check("rst_mem_ready", mem_ready, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_ld_done", ld_done, 0);
    check("rst_ld_count", ld_count, 0);
    check("rst_fetch_data", fetch_data, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_err", fetch_err, 0);

    // INIT: requests during the sweep must be ignored; READY after exactly 1024 edges.
    rst_n = 1'b1;
    fetch_en = 1'b1; ld_start = 1'b1;
    for (int i = 1; i <= 1024; i++) begin
      step();
      if (i == 10) begin fetch_en = 1'b0; ld_start = 1'b0; end
      if (i == 5) begin
        check("init_fetch_ignored", fetch_valid, 0);
        check("init_ld_ready", ld_ready, 0);
      end
      if (i == 7) check("small_init_not_ready", s_mem_ready, 0);
      if (i == 8) check("small_init_ready", s_mem_ready, 1);
      if (i == 1023) check("init_not_ready_1023", mem_ready, 0);
    end
    check("init_ready_1024", mem_ready, 1);

    fetch_check(10'd0, FILL, "fill_0");
    fetch_check(10'd511, FILL, "fill_511");
    fetch_check(10'd1023, FILL, "fill_1023");
    step();
    check("idle_valid", fetch_valid, 0);
    check("idle_data_hold", fetch_data, FILL);

    // ld_start with a concurrent fetch: fetch sees pre-load word 0.
    ld_start = 1'b1; fetch_en = 1'b1; fetch_addr = 10'd0;
    step();
    check("start_fetch_valid", fetch_valid, 1);
    check("start_fetch_data", fetch_data, FILL);
    check("load_ld_ready", ld_ready, 1);
    check("load_mem_ready", mem_ready, 0);
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 10'h029;
    step();
    check("load_fetch_ignored", fetch_valid, 0);
    ld_data = 10'h012;
    step();
    ld_data = 10'h2B3; ld_last = 1'b1;
    step();
    check("load1_done", ld_done, 1);
    check("load1_count", ld_count, 3);
    check("load1_ld_ready_drop", ld_ready, 0);
    check("load1_mem_ready", mem_ready, 1);
    ld_valid = 1'b0; ld_last = 1'b0; fetch_en = 1'b0;
    step();
    check("load1_done_pulse", ld_done, 0);
    check("load1_count_hold", ld_count, 3);
    fetch_check(10'd0, 10'h029, "l1_w0");
    fetch_check(10'd1, 10'h012, "l1_w1");
    fetch_check(10'd2, 10'h2B3, "l1_w2");
    fetch_check(10'd3, FILL, "l1_w3");

    // Stalled load: valid pattern 1,0,0,1,1(last); unaccepted data must not land.
    ld_start = 1'b1;
    step();
    check("load2_count_clr", ld_count, 0);
    ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("load2_ready_held", ld_ready, 1);
      ld_valid = (i == 0 || i >= 3);
      ld_last  = (i == 4);
      ld_data  = (i == 0) ? 10'h111 : (i == 3) ? 10'h222 : (i == 4) ? 10'h333 : 10'h3FF;
      step();
      if (i < 4) check("load2_no_done", ld_done, 0);
    end
    check("load2_done", ld_done, 1);
    check("load2_count", ld_count, 3);
    ld_valid = 1'b0; ld_last = 1'b0;
    fetch_check(10'd0, 10'h111, "l2_w0");
    fetch_check(10'd1, 10'h222, "l2_w1");
    fetch_check(10'd2, 10'h333, "l2_w2");
    fetch_check(10'd3, FILL, "l2_w3");

    // DEPTH=8: stream 10 words without ld_last; only 8 are accepted.
    s_ld_start = 1'b1;
    step();
    s_ld_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_ld_valid = 1'b1;
      s_ld_data  = 10'h100 + 10'(i);
      step();
      if (i == 7) begin
        check("small_done", s_ld_done, 1);
        check("small_count8", s_ld_count, 8);
        check("small_ready_drop", s_ld_ready, 0);
      end else if (i > 7) begin
        check("small_ready_low", s_ld_ready, 0);
        check("small_done_once", s_ld_done, 0);
        check("small_count_hold", s_ld_count, 8);
      end
    end
    s_ld_valid = 1'b0;
    s_fetch_en = 1'b1; s_fetch_addr = 10'd9;
    step();
    check("small_oob_data", s_fetch_data, FILL);
    check("small_oob_err", s_fetch_err, 1);
    check("small_oob_valid", s_fetch_valid, 1);
    s_fetch_addr = 10'd7;
    step();
    check("small_w7", s_fetch_data, 10'h107);
    check("small_w7_err", s_fetch_err, 0);
    s_fetch_addr = 10'd0;
    step();
    check("small_w0", s_fetch_data, 10'h100);
    s_fetch_en = 1'b0;

    // Reset mid-load after 2 of 5 words: outputs clear asynchronously, full refill follows.
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 10'h155;
    step();
    ld_data = 10'h0AA;
    step();
    ld_data = 10'h0F0;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ld_ready", ld_ready, 0);
    check("abort_ld_count", ld_count, 0);
    check("abort_mem_ready", mem_ready, 0);
    check("abort_fetch_data", fetch_data, 0);
    check("abort_ld_done", ld_done, 0);
    ld_valid = 1'b0;
    step();
    seen_done = seen_done | ld_done;
    rst_n = 1'b1;
    for (int i = 1; i <= 1024; i++) begin
      step();
      seen_done = seen_done | ld_done;
      if (i == 1023) check("reinit_not_ready", mem_ready, 0);
    end
    check("reinit_ready", mem_ready, 1);
    check("abort_no_done", seen_done, 0);
    fetch_check(10'd0, FILL, "refill_0");
    fetch_check(10'd1, FILL, "refill_1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
